// File: rtl/conv_batch_ctrl_if.sv
// Handshake and data bundle between the batch sequencer, its pixel source,
// the conv1 core and the result stream.
interface conv_batch_ctrl_if #(
  parameter int DW = 16,
  parameter int OW = 32
);
  logic                 src_valid;
  logic [DW-1:0]        src_data;
  logic                 src_ready;

  logic [DW-1:0]        conv_data_in;
  logic [4:0]           conv_row;
  logic [1:0]           conv_col;
  logic                 conv_rdata;
  logic signed [OW-1:0] conv_data_out;
  logic                 conv_wdata_fin;

  logic                 out_valid;
  logic [OW-1:0]        out_data;
  logic                 out_last;
  logic [5:0]           out_img;

  modport slave (
    input  src_valid, src_data, conv_data_out, conv_wdata_fin,
    output src_ready, conv_data_in, conv_row, conv_col, conv_rdata,
           out_valid, out_data, out_last, out_img
  );

  modport master (
    output src_valid, src_data, conv_data_out, conv_wdata_fin,
    input  src_ready, conv_data_in, conv_row, conv_col, conv_rdata,
           out_valid, out_data, out_last, out_img
  );
endinterface

// File: rtl/conv_batch_ctrl.sv
// Batch sequencer for the single-image conv1 core: streams pixels with
// coordinates, flushes and re-arms the core per image, and frames its results.
module conv_batch_ctrl #(
  parameter int ROWS    = 28,
  parameter int COLS    = 3,
  parameter int PIX     = 784,
  parameter int FLUSH   = 3,
  parameter int EXP_OUT = 784,
  parameter int DW      = 16,
  parameter int OW      = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [5:0]        n_img,
  conv_batch_ctrl_if.slave  bus,
  output logic              busy,
  output logic              img_done,
  output logic              batch_done,
  output logic              err_underrun,
  output logic              err_count
);

  localparam int PW = $clog2(PIX + 1);
  localparam int FW = $clog2(FLUSH + 1);
  localparam int RW = $clog2(EXP_OUT + 1) + 1;

  typedef enum logic [2:0] {
    S_IDLE, S_ARM, S_LOAD, S_FLUSH, S_GAP, S_DONE
  } state_t;

  state_t        state;
  logic [5:0]    n_lat;
  logic [5:0]    img_idx;
  logic [PW-1:0] pix_cnt;
  logic [FW-1:0] fl_cnt;
  logic [RW-1:0] res_cnt;

  logic [4:0]    row_nxt;
  logic [1:0]    col_nxt;
  logic [RW-1:0] res_inc;
  logic [DW-1:0] pix_mux;
  logic [OW-1:0] res_mux;

  // Row 31 is the idle marker, so the first slot after it lands on row 0;
  // the column phase only steps when a full row run wraps.
  always_comb begin
    row_nxt = bus.conv_row + 5'd1;
    col_nxt = bus.conv_col;
    if (bus.conv_row == 5'h1F) begin
      row_nxt = '0;
    end else if (bus.conv_row == 5'(ROWS - 1)) begin
      row_nxt = '0;
      col_nxt = (bus.conv_col == 2'(COLS - 1)) ? 2'd0 : bus.conv_col + 2'd1;
    end
  end

  always_comb begin
    res_inc = res_cnt;
    if (bus.conv_wdata_fin && (res_cnt != '1)) res_inc = res_cnt + 1'b1;
    pix_mux = bus.src_valid ? bus.src_data : '0;
    res_mux = bus.conv_wdata_fin ? bus.conv_data_out : '0;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state            <= S_IDLE;
      n_lat            <= '0;
      img_idx          <= '0;
      pix_cnt          <= '0;
      fl_cnt           <= '0;
      res_cnt          <= '0;
      bus.src_ready    <= 1'b0;
      bus.conv_data_in <= '0;
      bus.conv_row     <= 5'h1F;
      bus.conv_col     <= '0;
      bus.conv_rdata   <= 1'b0;
      bus.out_valid    <= 1'b0;
      bus.out_data     <= '0;
      bus.out_last     <= 1'b0;
      bus.out_img      <= '0;
      busy             <= 1'b0;
      img_done         <= 1'b0;
      batch_done       <= 1'b0;
      err_underrun     <= 1'b0;
      err_count        <= 1'b0;
    end else begin
      img_done      <= 1'b0;
      batch_done    <= 1'b0;
      bus.out_valid <= bus.conv_wdata_fin;
      bus.out_data  <= res_mux;
      bus.out_last  <= bus.conv_wdata_fin && (res_inc == RW'(EXP_OUT));
      bus.out_img   <= img_idx;

      if (state != S_IDLE) begin
        res_cnt <= res_inc;
        if (bus.conv_wdata_fin && (res_cnt >= RW'(EXP_OUT))) err_count <= 1'b1;
      end

      case (state)
        S_IDLE: begin
          if (start) begin
            n_lat        <= n_img;
            img_idx      <= '0;
            res_cnt      <= '0;
            err_underrun <= 1'b0;
            err_count    <= 1'b0;
            busy         <= 1'b1;
            if (n_img != 6'd0) begin
              state         <= S_ARM;
              bus.src_ready <= 1'b1;
            end else begin
              state <= S_DONE;
            end
          end
        end
        S_ARM: begin
          if (bus.src_valid) begin
            state            <= S_LOAD;
            bus.conv_rdata   <= 1'b1;
            bus.conv_data_in <= bus.src_data;
            bus.conv_row     <= row_nxt;
            bus.conv_col     <= col_nxt;
            pix_cnt          <= PW'(1);
          end
        end
        // Every LOAD cycle is a slot; a missing pixel is sent as zero so
        // the core's counters stay aligned with the image.
        S_LOAD: begin
          bus.conv_rdata   <= 1'b1;
          bus.conv_data_in <= pix_mux;
          bus.conv_row     <= row_nxt;
          bus.conv_col     <= col_nxt;
          pix_cnt          <= pix_cnt + 1'b1;
          if (!bus.src_valid) err_underrun <= 1'b1;
          if (pix_cnt == PW'(PIX - 1)) begin
            state         <= S_FLUSH;
            bus.src_ready <= 1'b0;
            fl_cnt        <= '0;
          end
        end
        S_FLUSH: begin
          bus.conv_data_in <= '0;
          bus.conv_row     <= row_nxt;
          bus.conv_col     <= col_nxt;
          fl_cnt           <= fl_cnt + 1'b1;
          if (fl_cnt == FW'(FLUSH - 1)) state <= S_GAP;
        end
        // res_inc folds in a result arriving in this cycle before judging the image.
        S_GAP: begin
          bus.conv_rdata   <= 1'b0;
          bus.conv_data_in <= '0;
          bus.conv_row     <= 5'h1F;
          bus.conv_col     <= '0;
          img_done         <= 1'b1;
          img_idx          <= img_idx + 6'd1;
          res_cnt          <= '0;
          if (res_inc != RW'(EXP_OUT)) err_count <= 1'b1;
          if (({1'b0, img_idx} + 7'd1) < {1'b0, n_lat}) begin
            state         <= S_ARM;
            bus.src_ready <= 1'b1;
          end else begin
            state <= S_DONE;
          end
        end
        S_DONE: begin
          batch_done <= 1'b1;
          busy       <= 1'b0;
          state      <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_conv_batch_ctrl.sv
// Scoreboard bench for conv_batch_ctrl: drivers push expected pixel slots,
// results and status events; independent monitors pop and compare.
module tb_conv_batch_ctrl;
  localparam int ROWS = 28, COLS = 3, PIX = 784, FLUSH = 3, EXP_OUT = 784;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic [5:0] n_img;
  logic       busy, img_done, batch_done, err_underrun, err_count;

  conv_batch_ctrl_if #(.DW(16), .OW(32)) bus();

  conv_batch_ctrl #(
    .ROWS(ROWS), .COLS(COLS), .PIX(PIX), .FLUSH(FLUSH),
    .EXP_OUT(EXP_OUT), .DW(16), .OW(32)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .n_img(n_img), .bus(bus),
    .busy(busy), .img_done(img_done), .batch_done(batch_done),
    .err_underrun(err_underrun), .err_count(err_count)
  );

  always #5 clk = ~clk;

  typedef struct packed { logic [15:0] data; logic [4:0] row; logic [1:0] col; } pix_t;
  typedef struct packed { logic [31:0] data; logic last; logic [5:0] img; } res_t;
  typedef struct { bit is_batch; bit eu; bit ec; bit from_start; } stat_t;

  pix_t  pix_q[$];
  res_t  out_q[$];
  int    run_q[$];
  int    gap_q[$];
  stat_t stat_q[$];

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int start_cyc = 0;
  int core_n = PIX;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_output(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s actual=%0h expected=%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic report_missing(input string name);
    checks++;
    errors++;
    $display("[TB] FAIL %s actual=event expected=none (cycle %0d)", name, cyc);
  endtask

  function automatic logic [15:0] pix_value(input int img, input int p);
    return 16'(p * 37 + img * 1000 + 1);
  endfunction

  function automatic logic [31:0] res_value(input int img, input int k);
    return 32'(img * 32'h0100_0000) ^ 32'(k * 32'h0001_0003) ^ 32'h8000_0005;
  endfunction

  // Pixel-slot monitor: coordinates/data per rdata slot, high-run and gap lengths.
  int hi_run = 0, lo_run = 0;
  bit prev_rd = 1'b0, gap_armed = 1'b0;
  always @(negedge clk) begin
    pix_t e;
    if (!rst) begin
      hi_run = 0; lo_run = 0; prev_rd = 1'b0; gap_armed = 1'b0;
    end else begin
      if (bus.conv_rdata) begin
        if (!prev_rd && gap_armed) begin
          if (gap_q.size() == 0) report_missing("rdata_gap_unexpected");
          else check_output("rdata_gap_len", 64'(lo_run), 64'(gap_q.pop_front()));
          gap_armed = 1'b0;
        end
        hi_run++;
        lo_run = 0;
        if (pix_q.size() == 0) report_missing("pix_unexpected");
        else begin
          e = pix_q.pop_front();
          check_output("pix_slot", {bus.conv_data_in, bus.conv_row, bus.conv_col}, e);
        end
      end else begin
        if (prev_rd) begin
          if (run_q.size() == 0) report_missing("rdata_run_unexpected");
          else check_output("rdata_run_len", 64'(hi_run), 64'(run_q.pop_front()));
          gap_armed = 1'b1;
        end
        hi_run = 0;
        lo_run++;
      end
      if (batch_done) gap_armed = 1'b0;
      prev_rd = bus.conv_rdata;
    end
  end

  // Core model: one result per rdata slot for the first core_n slots of an image.
  int emitted = 0, core_img = 0;
  bit core_prev = 1'b0;
  always @(negedge clk) begin
    logic [31:0] r;
    if (!rst) begin
      emitted = 0; core_img = 0; core_prev = 1'b0;
      bus.conv_wdata_fin = 1'b0;
      bus.conv_data_out  = '0;
    end else begin
      if (!busy) core_img = 0;
      if (core_prev && !bus.conv_rdata) begin
        core_img++;
        emitted = 0;
      end
      if (bus.conv_rdata && emitted < core_n) begin
        r = res_value(core_img, emitted);
        bus.conv_wdata_fin = 1'b1;
        bus.conv_data_out  = r;
        out_q.push_back('{data: r, last: (emitted + 1 == EXP_OUT), img: 6'(core_img)});
        emitted++;
      end else begin
        bus.conv_wdata_fin = 1'b0;
      end
      core_prev = bus.conv_rdata;
    end
  end

  always @(negedge clk) begin
    if (rst && bus.out_valid) begin
      if (out_q.size() == 0) report_missing("out_unexpected");
      else check_output("out_beat", {bus.out_data, bus.out_last, bus.out_img}, out_q.pop_front());
    end
  end

  int last_img_cyc = 0;
  always @(negedge clk) begin
    stat_t s;
    if (rst && (img_done || batch_done)) begin
      if (stat_q.size() == 0) report_missing("status_unexpected");
      else begin
        s = stat_q.pop_front();
        check_output("status_kind", {img_done, batch_done}, s.is_batch ? 2'b01 : 2'b10);
        check_output("err_underrun", err_underrun, s.eu);
        check_output("err_count", err_count, s.ec);
        if (batch_done)
          check_output("batch_delay", 64'(cyc - (s.from_start ? start_cyc : last_img_cyc)),
                       s.from_start ? 64'd2 : 64'd1);
        if (img_done) last_img_cyc = cyc;
      end
    end
  end

  task automatic issue_start(input logic [5:0] n);
    @(negedge clk);
    start = 1'b1;
    n_img = n;
    start_cyc = cyc;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic apply_stimulus(input int img, input int stall, input int ur_lo, input int ur_hi,
                                input int start_at, input int stop_at);
    int tmo;
    logic v;
    logic [15:0] d;
    if (stop_at >= PIX) run_q.push_back(PIX + FLUSH);
    if (img > 0) gap_q.push_back(stall + 1);
    bus.src_valid = 1'b0;
    tmo = 0;
    while (!bus.src_ready && tmo < 50) begin
      @(negedge clk);
      tmo++;
    end
    if (!bus.src_ready) begin
      report_missing("src_ready_arm_timeout");
      return;
    end
    repeat (stall) @(negedge clk);
    for (int p = 0; p < PIX; p++) begin
      if (p > 0) @(negedge clk);
      if (p == stop_at) begin
        bus.src_valid = 1'b0;
        return;
      end
      start = (p == start_at);
      if (p == start_at) n_img = 6'd5;
      v = !(p >= ur_lo && p <= ur_hi);
      d = pix_value(img, p);
      bus.src_valid = v;
      bus.src_data  = v ? d : 16'hDEAD;
      if (p > 0) check_output("src_ready_load", bus.src_ready, 1'b1);
      pix_q.push_back('{data: v ? d : 16'h0, row: 5'(p % ROWS), col: 2'((p / ROWS) % COLS)});
    end
    for (int f = 0; f < FLUSH; f++)
      pix_q.push_back('{data: 16'h0, row: 5'((PIX + f) % ROWS), col: 2'(((PIX + f) / ROWS) % COLS)});
    @(negedge clk);
    bus.src_valid = 1'b0;
    start = 1'b0;
  endtask

  task automatic wait_idle();
    int tmo = 0;
    while ((busy || stat_q.size() != 0) && tmo < 3000) begin
      @(negedge clk);
      tmo++;
    end
    if (tmo >= 3000) report_missing("idle_timeout");
    @(negedge clk);
  endtask

  task automatic run_batch(input int n, input int stall, input int ur_lo, input int ur_hi,
                           input int start_at, input int ncore, input bit exp_eu, input bit exp_ec);
    core_n = ncore;
    for (int i = 0; i < n; i++)
      stat_q.push_back('{is_batch: 1'b0, eu: exp_eu, ec: exp_ec, from_start: 1'b0});
    stat_q.push_back('{is_batch: 1'b1, eu: exp_eu, ec: exp_ec, from_start: (n == 0)});
    issue_start(6'(n));
    for (int i = 0; i < n; i++) apply_stimulus(i, stall, ur_lo, ur_hi, start_at, PIX);
    wait_idle();
  endtask

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog actual=running expected=finished");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    rst = 1'b0;
    start = 1'b0;
    n_img = '0;
    bus.src_valid = 1'b0;
    bus.src_data = '0;
    repeat (3) @(negedge clk);
    check_output("reset_rdata", bus.conv_rdata, 1'b0);
    check_output("reset_row", bus.conv_row, 5'h1F);
    check_output("reset_col_data", {bus.conv_col, bus.conv_data_in}, 18'h0);
    check_output("reset_ready_busy", {bus.src_ready, busy}, 2'b00);
    check_output("reset_out", {bus.out_valid, bus.out_last, bus.out_img, bus.out_data}, 40'h0);
    check_output("reset_status", {img_done, batch_done, err_underrun, err_count}, 4'h0);
    #2 rst = 1'b1;

    $display("[TB] reset in the middle of LOAD");
    core_n = PIX;
    issue_start(6'd1);
    apply_stimulus(0, 0, -1, -1, -1, 400);
    check_output("midload_rdata", bus.conv_rdata, 1'b1);
    #2 rst = 1'b0;
    #1;
    check_output("async_rdata", bus.conv_rdata, 1'b0);
    check_output("async_row", bus.conv_row, 5'h1F);
    check_output("async_col_data", {bus.conv_col, bus.conv_data_in}, 18'h0);
    check_output("async_ready_busy", {bus.src_ready, busy}, 2'b00);
    check_output("async_out", {bus.out_valid, bus.out_data}, 33'h0);
    pix_q.delete(); out_q.delete(); run_q.delete(); gap_q.delete(); stat_q.delete();
    repeat (2) @(negedge clk);
    #2 rst = 1'b1;

    $display("[TB] single image, continuous source");
    run_batch(1, 0, -1, -1, -1, PIX, 1'b0, 1'b0);

    $display("[TB] three images with ARM stalls");
    run_batch(3, 5, -1, -1, -1, PIX, 1'b0, 1'b0);

    $display("[TB] underrun at pixels 100-101, start ignored while busy");
    run_batch(1, 0, 100, 101, 300, PIX, 1'b1, 1'b0);

    $display("[TB] short result count");
    run_batch(1, 0, -1, -1, -1, EXP_OUT - 1, 1'b0, 1'b1);
    check_output("err_count_sticky", err_count, 1'b1);

    $display("[TB] zero-image batch");
    run_batch(0, 0, -1, -1, -1, PIX, 1'b0, 1'b0);
    check_output("final_idle", {busy, bus.src_ready, bus.conv_rdata}, 3'b000);

    check_output("pix_q_drained", 64'(pix_q.size()), 64'd0);
    check_output("out_q_drained", 64'(out_q.size()), 64'd0);
    check_output("run_q_drained", 64'(run_q.size()), 64'd0);
    check_output("gap_q_drained", 64'(gap_q.size()), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
